// File: rtl/countdown_timer_32.sv
// countdown_timer_32: loadable 32-bit down-counter with start/stop control, terminal-count pulse and optional auto-reload
module countdown_timer_32 #(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        start,
  input  logic        stop,
  output logic [31:0] count,
  output logic        busy,
  output logic        done,
  output logic        tc
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  state_t      r_state, w_state_nxt;
  logic [31:0] r_count, w_count_nxt;
  logic [31:0] r_reload, w_reload_nxt;
  logic        r_tc, w_tc_nxt;
  logic        w_cnt_zero, w_cnt_one, w_rel_zero, w_tick;
  assign w_cnt_zero = r_count == 32'd0;
  assign w_cnt_one  = r_count == 32'd1;
  assign w_rel_zero = r_reload == 32'd0;
  assign w_tick     = ce && w_cnt_one;
  // Next-state and datapath: load dominates, then per-state start/stop/ce handling; the terminal tick beats stop
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_tc_nxt     = 1'b0;
    if (load) begin
      w_count_nxt  = load_val;
      w_reload_nxt = load_val;
      w_state_nxt  = r_state == ST_RUN ? ST_RUN : ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: if (start) begin
          w_state_nxt = w_cnt_zero ? ST_DONE : ST_RUN;
          w_tc_nxt    = w_cnt_zero;
        end
        ST_RUN: if (w_tick) begin
          w_tc_nxt    = 1'b1;
          w_count_nxt = AUTO_RELOAD ? r_reload : 32'd0;
          w_state_nxt = AUTO_RELOAD ? ST_RUN : ST_DONE;
        end else if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (ce && !w_cnt_zero) begin
          w_count_nxt = r_count - 32'd1;
        end
        ST_DONE: if (start) begin
          w_count_nxt = r_reload;
          w_state_nxt = w_rel_zero ? ST_DONE : ST_RUN;
          w_tc_nxt    = w_rel_zero;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end
  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end
  // Count, reload and terminal-count pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_tc     <= w_tc_nxt;
    end
  end
  assign count = r_count;
  assign busy  = r_state == ST_RUN;
  assign done  = r_state == ST_DONE;
  assign tc    = r_tc;
endmodule

// File: doc/countdown_timer_32.md
COUNTDOWN_TIMER_32 -- requirements
Module: countdown_timer_32

Interface
REQ-001 SHALL have parameter AUTO_RELOAD, default 0, meaning: 1 = reload and continue at terminal count; 0 = stop in DONE.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ce  input  1  count enable; one decrement per cycle with ce=1 while in RUN.
REQ-005 SHALL have port load  input  1  one-cycle strobe that captures load_val.
REQ-006 SHALL have port load_val  input  32  unsigned value written to count and reload_reg on load.
REQ-007 SHALL have port start  input  1  one-cycle strobe that begins countdown.
REQ-008 SHALL have port stop  input  1  one-cycle strobe that aborts countdown, holding count.
REQ-009 SHALL have port count  output  32  current remaining count, registered.
REQ-010 SHALL have port busy  output  1  high iff state == RUN.
REQ-011 SHALL have port done  output  1  high iff state == DONE.
REQ-012 SHALL have port tc  output  1  registered one-cycle terminal-count pulse.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE; busy and done decode from the state alone.
REQ-014 SHALL hold an internal 32-bit reload_reg that is written only by load.
REQ-015 SHALL, on load in any state, set count <= load_val and reload_reg <= load_val; DONE -> IDLE, IDLE stays IDLE, RUN stays RUN; no decrement occurs that cycle.
REQ-016 SHALL give load priority over start, stop and ce in the same cycle; start and stop are ignored that cycle.
REQ-017 SHALL, on start in IDLE with count != 0, enter RUN next cycle; the first decrement may occur in the cycle after start.
REQ-018 SHALL, on start in IDLE with count == 0, enter DONE and pulse tc next cycle.
REQ-019 SHALL, on start in DONE, set count <= reload_reg and enter RUN; if reload_reg == 0, re-enter DONE and pulse tc instead.
REQ-020 SHALL ignore start while in RUN.
REQ-021 SHALL, in RUN with ce=1 and count > 1, decrement count by 1.
REQ-022 SHALL, in RUN with ce=1 and count == 1, set tc=1 for exactly the next cycle.
REQ-023 SHALL, at that terminal tick with AUTO_RELOAD=0, set count <= 0 and enter DONE.
REQ-024 SHALL, at that terminal tick with AUTO_RELOAD=1, set count <= reload_reg and stay in RUN, giving a period of reload_reg ce-ticks.
REQ-025 SHALL hold count in RUN when ce=0.
REQ-026 SHALL, on stop in RUN, enter IDLE with count held; stop SHALL be ignored in IDLE and DONE.
REQ-027 SHALL let the terminal tick win over a simultaneous stop: tc pulses and the REQ-023/024 transition is taken.
REQ-028 SHALL ignore ce outside RUN, and count SHALL never wrap below 0.
REQ-029 SHALL keep tc low in every cycle not defined by REQ-018, REQ-019 or REQ-022.

Reset
REQ-030 SHALL, on reset=1 at posedge clk, set state=IDLE, count=0, reload_reg=0 and tc=0 (hence busy=0, done=0), overriding all other inputs in any state, including mid-RUN.
REQ-031 SHALL be a power-up-equivalent state after one reset cycle, with no further initialisation required.

Verification
REQ-032 SHALL cover load_val=3, load, start, ce=1 continuously, AUTO_RELOAD=0 -> count 3,2,1,0; tc high one cycle with count=0; done=1; busy=0.
REQ-033 SHALL cover load_val=2 under AUTO_RELOAD=1 with ce=1 continuously -> count 2,1,2,1,...; tc pulses every 2 cycles; busy stays 1.
REQ-034 SHALL cover load 5, start, 2 ce ticks, stop -> IDLE with count=3; a further start resumes 3->0.
REQ-035 SHALL cover start with count=0 -> next cycle done=1 and tc=1 for one cycle, count=0.
REQ-036 SHALL cover simultaneous load(7)+start in IDLE -> count=7, state stays IDLE; simultaneous stop with the count==1 tick -> tc=1 and DONE.
REQ-037 SHALL cover reset asserted mid-RUN at count=0x0000_1000 -> next cycle count=0, busy=0, done=0, tc=0, and start is then ignored-equivalent (count==0 -> DONE).
